// File: rtl/softmax_out_serializer_pkg.sv
// softmax_out_serializer_pkg: lane geometry, FSM states and lane-select helper shared by the serializer and benches
package softmax_out_serializer_pkg;
  localparam int W = 16;
  localparam int FRAC = 10;
  localparam int N_LANES = 32;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic logic [W-1:0] lane_sel(input logic [N_LANES*W-1:0] v, input int unsigned i);
    return v[W*i +: W];
  endfunction
endpackage

// File: rtl/softmax_out_serializer_vec_fifo.sv
// vec_fifo: DEPTH-entry vector FIFO with head read-out, level and full/empty flags
module vec_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  // Storage is left unreset; it is only observed once written.
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  assign dout = mem[rd];
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/softmax_out_serializer.sv
// softmax_out_serializer: buffers softmax vectors and streams them one lane per valid/ready handshake
module softmax_out_serializer
  import softmax_out_serializer_pkg::*;
#(
  parameter int N = N_LANES,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(N),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           valid_in,
  input  logic [N*W-1:0] prob_flat,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [IW-1:0]  out_idx,
  output logic [LW-1:0]  level,
  output logic           overflow
);
  logic [N*W-1:0] head;
  logic full, empty, xfer, pop, push, drop;
  logic [IW-1:0] idx;
  state_t state;
  assign xfer = en & out_valid & out_ready;
  assign pop = xfer & out_last;
  assign push = en & valid_in & (!full | pop);
  assign drop = en & valid_in & full & !pop;
  vec_fifo #(.DEPTH(DEPTH), .DW(N*W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(prob_flat),
    .dout(head), .level(level), .full(full), .empty(empty)
  );
  // Stay streaming whenever a vector remains after this edge, so push-on-pop never bubbles.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      state <= (push | (level > LW'(1)) | (!empty & !pop)) ? STREAM : IDLE;
      if (xfer) idx <= out_last ? '0 : idx + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  assign out_valid = state == STREAM;
  assign out_idx = idx;
  assign out_last = idx == IW'(N-1);
  assign out_data = out_valid ? lane_sel((N_LANES*W)'(head), 32'(idx)) : '0;
endmodule

// File: tb/tb_softmax_out_serializer.sv
// tb_softmax_out_serializer: scoreboard bench with a vector-queue reference model of the serializer
module tb_softmax_out_serializer;
  import softmax_out_serializer_pkg::*;
  localparam int N = 32, DEPTH = 4, IW = 5, LW = 3;
  logic clk = 0, rst = 1, en = 0, valid_in = 0, out_ready = 0;
  logic [N*W-1:0] prob_flat = '0;
  logic [W-1:0] out_data;
  logic out_valid, out_last, overflow;
  logic [IW-1:0] out_idx;
  logic [LW-1:0] level;
  softmax_out_serializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .prob_flat(prob_flat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_idx(out_idx), .level(level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {logic [W-1:0] d; int idx;} word_t;
  word_t exp_q[$];
  int mcnt = 0, mpos = 0, vectors = 0, miscompares = 0, dut_xfer = 0;
  bit movf = 0, xf, pp, acc;
  logic [N*W-1:0] x [3];
  task automatic chk(input string nm, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask
  // Reference model: a queue of accepted vectors plus the head lane position.
  always @(posedge clk or negedge rst)
    if (!rst) begin
      mcnt = 0; mpos = 0; movf = 0; exp_q.delete();
    end else if (en) begin
      xf = out_ready && mcnt > 0;
      pp = xf && mpos == N-1;
      acc = valid_in && (mcnt < DEPTH || pp);
      if (xf) mpos = pp ? 0 : mpos + 1;
      if (pp) mcnt--;
      if (acc) begin
        mcnt++;
        for (int i = 0; i < N; i++) exp_q.push_back(word_t'{prob_flat[W*i +: W], i});
      end else if (valid_in) movf = 1;
    end
  always @(negedge clk)
    if (rst) begin
      chk("out_valid", out_valid, mcnt > 0);
      chk("level", level, mcnt);
      chk("overflow", overflow, movf);
      if (out_valid && out_ready && en) dut_xfer++;
      if (mcnt > 0) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 0, 1);
        else begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_idx", out_idx, exp_q[0].idx);
          chk("out_last", out_last, exp_q[0].idx == N-1);
          if (en && out_ready) void'(exp_q.pop_front());
        end
      end
    end
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    rst = 0; #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1; rst = 1;
  endtask
  task automatic push(input logic [N*W-1:0] v);
    valid_in = 1; prob_flat = v; tick(); valid_in = 0;
  endtask
  task automatic wait_pos(input int p);
    int b = 0;
    while (!(mcnt > 0 && mpos == p) && b < 500) begin tick(); b++; end
    if (b >= 500) chk("wait_timeout", 0, 1);
  endtask
  function automatic logic [N*W-1:0] rvec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = W'($urandom);
    return v;
  endfunction
  initial begin
    logic [W-1:0] pat [8];
    int base, sp;
    pat = '{16'hF5BE, 16'h042B, 16'h0B26, 16'hFBCF, 16'h0B13, 16'hFDE2, 16'h061D, 16'h061D};
    for (int i = 0; i < N; i++) x[0][W*i +: W] = pat[i%8];
    x[1] = rvec(); x[2] = rvec();
    en = 1;
    do_reset();
    out_ready = 1; base = dut_xfer;
    push(x[0]); tick(40);
    chk("single_xfers", dut_xfer - base, 32);
    do_reset();
    base = dut_xfer;
    push(x[0]);
    for (int c = 0; c < 140; c++) begin out_ready = (c % 4 == 0 || c % 4 == 3); tick(); end
    chk("bp_xfers", dut_xfer - base, 32);
    do_reset();
    out_ready = 1; base = dut_xfer;
    for (int k = 0; k < 12; k++) begin valid_in = 1; prob_flat = x[k%3]; tick(); end
    valid_in = 0;
    chk("burst_overflow", overflow, 1);
    tick(140);
    chk("burst_xfers", dut_xfer - base, 128);
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 4; k++) push(x[k%3]);
    chk("full_level", level, 4);
    out_ready = 1;
    wait_pos(N-1);
    push(x[1]);
    chk("full_pop_level", level, 4);
    chk("full_pop_overflow", overflow, 0);
    tick(5*N);
    do_reset();
    out_ready = 1;
    push(x[2]); tick(10);
    sp = mpos; base = dut_xfer;
    en = 0; valid_in = 1; prob_flat = x[1];
    tick(5);
    chk("en_xfers", dut_xfer - base, 0);
    chk("en_idx", out_idx, sp);
    chk("en_overflow", overflow, 0);
    en = 1; valid_in = 0;
    tick(40);
    do_reset();
    push(x[0]);
    wait_pos(10);
    #2 rst = 0; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_idx", out_idx, 0);
    @(posedge clk); #1; rst = 1;
    push(x[1]); tick(40);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom % 8) != 0;
      valid_in = ($urandom % 4) == 0;
      out_ready = ($urandom % 4) != 0;
      prob_flat = rvec();
      tick();
    end
    en = 1; valid_in = 0; out_ready = 1;
    tick(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
